// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and default sizing for cache_port_arbiter.
//   arb_state_e      - arbiter FSM encoding (IDLE/ISSUE/RESP)
//   NREQ_DEF/AW_DEF/DW_DEF - default requester count, address and data widths
package cache_arb_pkg;

   localparam int unsigned NREQ_DEF = 2;
   localparam int unsigned AW_DEF   = 7;
   localparam int unsigned DW_DEF   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational requester picker.
//   req     in  NREQ : pending requests
//   ptr     in  IW   : last granted index (only when CACHE_ARB_RR_EN is defined)
//   grant   out NREQ : one-hot winner
//   idx     out IW   : binary index of the winner
//   any_req out 1    : at least one request pending
// CACHE_ARB_RR_EN defined: round-robin, search starts at ptr+1 (mod NREQ).
// Undefined: fixed priority, lowest index wins.
module rr_pick
   import cache_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
`ifdef CACHE_ARB_RR_EN
   input  logic [IW-1:0]   ptr,
`endif
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any_req
);

   // Scan NREQ candidates in search order; first pending one wins.
   always_comb begin
      int unsigned c;
      grant   = '0;
      idx     = '0;
      any_req = 1'b0;
      c       = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef CACHE_ARB_RR_EN
         c = (32'(ptr) + k + 32'd1) % NREQ;
`else
         c = k;
`endif
         if (!any_req && req[c]) begin
            any_req  = 1'b1;
            grant[c] = 1'b1;
            idx      = IW'(c);
         end
      end
   end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares the single CPU-side cache port among NREQ masters.
//   clk, rst_n             : clock, async active-low reset
//   req_valid/rw/addr/din  : per-requester request (packed, requester i at [i*W +: W])
//   req_ready              : one-hot acceptance (combinational, IDLE only)
//   rsp_valid, rsp_rdata   : one-cycle tagged completion and read data
//   c_valid/rw/addr/din    : registered request toward the cache
//   c_ready, c_dout        : cache handshake and read data
// Build option: CACHE_ARB_RR_EN selects round-robin, otherwise fixed priority.
module cache_port_arbiter
   import cache_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned DW   = DW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req_valid,
   input  logic [NREQ-1:0]  req_rw,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_din,
   output logic [NREQ-1:0]  req_ready,
   output logic [NREQ-1:0]  rsp_valid,
   output logic [DW-1:0]    rsp_rdata,
   output logic             c_valid,
   output logic             c_rw,
   output logic [AW-1:0]    c_addr,
   output logic [DW-1:0]    c_din,
   input  logic             c_ready,
   input  logic [DW-1:0]    c_dout
);

   localparam int unsigned IW = $clog2(NREQ);

   arb_state_e       state;
   logic [IW-1:0]    gnt_q;
   logic [NREQ-1:0]  grant;
   logic [IW-1:0]    grant_idx;
   logic             any_req;

`ifdef CACHE_ARB_RR_EN
   logic [IW-1:0]    ptr_q;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req     (req_valid),
`ifdef CACHE_ARB_RR_EN
      .ptr     (ptr_q),
`endif
      .grant   (grant),
      .idx     (grant_idx),
      .any_req (any_req)
   );

   // Acceptance is only offered in IDLE and never while reset is asserted.
   assign req_ready = (rst_n && (state == ST_IDLE)) ? grant : '0;

   // FSM, latched request (held on the c_* outputs) and response register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         gnt_q     <= '0;
         c_valid   <= 1'b0;
         c_rw      <= 1'b0;
         c_addr    <= '0;
         c_din     <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
`ifdef CACHE_ARB_RR_EN
         ptr_q     <= IW'(NREQ - 1);
`endif
      end else begin
         rsp_valid <= '0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  gnt_q   <= grant_idx;
                  c_valid <= 1'b1;
                  c_rw    <= req_rw[grant_idx];
                  c_addr  <= req_addr[grant_idx*AW +: AW];
                  c_din   <= req_din[grant_idx*DW +: DW];
`ifdef CACHE_ARB_RR_EN
                  ptr_q   <= grant_idx;
`endif
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // c_valid is high throughout ISSUE; c_* hold until the cache takes it.
               if (c_ready) begin
                  c_valid <= 1'b0;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               // c_rw still holds the latched direction of this transaction.
               if (!c_rw) rsp_rdata <= c_dout;
               rsp_valid[gnt_q] <= 1'b1;
               state            <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: randomized bench with a transaction-level reference
// model of the arbiter and a behavioural cache memory.
module tb_cache_port_arbiter;
   import cache_arb_pkg::*;

   localparam int unsigned NREQ = NREQ_DEF;
   localparam int unsigned AW   = AW_DEF;
   localparam int unsigned DW   = DW_DEF;
`ifdef CACHE_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_rw;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_din;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              c_valid;
   logic              c_rw;
   logic [AW-1:0]     c_addr;
   logic [DW-1:0]     c_din;
   logic              c_ready;
   logic [DW-1:0]     c_dout;

   cache_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_din   (req_din),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .c_valid   (c_valid),
      .c_rw      (c_rw),
      .c_addr    (c_addr),
      .c_din     (c_din),
      .c_ready   (c_ready),
      .c_dout    (c_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_pass;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Requester-side pending requests
   bit              hold   [NREQ];
   logic            r_rw   [NREQ];
   logic [AW-1:0]   r_addr [NREQ];
   logic [DW-1:0]   r_din  [NREQ];

   // Behavioural cache contents; unwritten lines read as 0xDEADBEEF
   logic [DW-1:0]   mem [logic [AW-1:0]];

   // Reference model: the transaction in flight and the expected outputs
   bit              cur_active;
   bit              cur_taken;
   int              cur_id;
   logic            cur_rw;
   logic [AW-1:0]   cur_addr;
   logic [DW-1:0]   cur_din;
   int              last;
   logic            exp_c_valid;
   logic            exp_c_rw;
   logic [AW-1:0]   exp_c_addr;
   logic [DW-1:0]   exp_c_din;
   logic [NREQ-1:0] exp_rsp_valid;
   logic [DW-1:0]   exp_rdata;

   // Observation log
   int              cyc;
   int              gq_id[$];
   int              gq_cyc[$];
   int              rsp_cnt;
   int              obs_rsp_cyc;
   int              obs_rsp_id;
   logic [DW-1:0]   obs_rsp_data;

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return DW'(32'hDEADBEEF);
   endfunction

   function automatic int pick(input logic [NREQ-1:0] v, input int lst);
      int start;
      start = RR_EN ? lst + 1 : 0;
      for (int d = 0; d < NREQ; d++) begin
         if (v[(start + d) % NREQ]) return (start + d) % NREQ;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int gq_id_at(input int k);
      return (k < gq_id.size()) ? gq_id[k] : -1;
   endfunction

   function automatic int gq_cyc_at(input int k);
      return (k < gq_cyc.size()) ? gq_cyc[k] : -1000;
   endfunction

   task automatic drive_ports();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]           = hold[i];
         req_rw[i]              = r_rw[i];
         req_addr[i*AW +: AW]   = r_addr[i];
         req_din[i*DW +: DW]    = r_din[i];
      end
   endtask

   task automatic model_reset();
      cur_active    = 1'b0;
      cur_taken     = 1'b0;
      cur_id        = 0;
      last          = NREQ - 1;
      exp_c_valid   = 1'b0;
      exp_c_rw      = 1'b0;
      exp_c_addr    = '0;
      exp_c_din     = '0;
      exp_rsp_valid = '0;
      exp_rdata     = '0;
      for (int i = 0; i < NREQ; i++) begin
         hold[i]   = 1'b0;
         r_rw[i]   = 1'b0;
         r_addr[i] = '0;
         r_din[i]  = '0;
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step(input int p_req, input int p_rdy);
      logic [NREQ-1:0] hv;
      logic [NREQ-1:0] exp_ready;
      int              w;
      check("c_valid",   c_valid,   exp_c_valid);
      check("c_rw",      c_rw,      exp_c_rw);
      check("c_addr",    c_addr,    exp_c_addr);
      check("c_din",     c_din,     exp_c_din);
      check("rsp_valid", rsp_valid, exp_rsp_valid);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      if (rsp_valid != '0) begin
         rsp_cnt++;
         obs_rsp_cyc  = cyc;
         obs_rsp_id   = onehot_idx(rsp_valid);
         obs_rsp_data = rsp_rdata;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!hold[i] && int'($urandom_range(99)) < p_req) begin
            hold[i]   = 1'b1;
            r_rw[i]   = 1'($urandom_range(1));
            r_addr[i] = AW'($urandom_range(15));
            r_din[i]  = DW'($urandom);
         end
      end
      drive_ports();
      c_ready = (int'($urandom_range(99)) < p_rdy);
      c_dout  = mem_rd(c_addr);
      #1;
      for (int i = 0; i < NREQ; i++) hv[i] = hold[i];
      w = cur_active ? -1 : pick(hv, last);
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      if (req_ready != '0) begin
         gq_id.push_back(onehot_idx(req_ready));
         gq_cyc.push_back(cyc);
      end
      // Advance the model across the coming rising edge
      exp_rsp_valid = '0;
      if (cur_active && cur_taken) begin
         exp_rsp_valid[cur_id] = 1'b1;
         if (!cur_rw) exp_rdata = mem_rd(cur_addr);
         cur_active = 1'b0;
         cur_taken  = 1'b0;
      end else if (cur_active) begin
         if (c_ready) begin
            if (cur_rw) mem[cur_addr] = cur_din;
            cur_taken   = 1'b1;
            exp_c_valid = 1'b0;
         end
      end else if (w >= 0) begin
         cur_active  = 1'b1;
         cur_id      = w;
         cur_rw      = r_rw[w];
         cur_addr    = r_addr[w];
         cur_din     = r_din[w];
         hold[w]     = 1'b0;
         last        = w;
         exp_c_valid = 1'b1;
         exp_c_rw    = r_rw[w];
         exp_c_addr  = r_addr[w];
         exp_c_din   = r_din[w];
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n, input int p_req, input int p_rdy);
      for (int k = 0; k < n; k++) step(p_req, p_rdy);
   endtask

   int g;
   int rsp_before;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      rsp_cnt  = 0;
      obs_rsp_cyc  = -1;
      obs_rsp_id   = -1;
      obs_rsp_data = '0;
      model_reset();
      rst_n   = 1'b0;
      c_ready = 1'b1;
      c_dout  = '0;

      // Reset with traffic present: req0 reads 0x05, req1 writes 0x08
      hold[0] = 1'b1; r_rw[0] = 1'b0; r_addr[0] = 7'h05; r_din[0] = '0;
      hold[1] = 1'b1; r_rw[1] = 1'b1; r_addr[1] = 7'h08; r_din[1] = 32'h12345678;
      drive_ports();
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, '0);
      check("rst_c_valid",   c_valid,   1'b0);
      check("rst_c_addr",    c_addr,    '0);
      check("rst_c_din",     c_din,     '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rsp_rdata", rsp_rdata, '0);
      rst_n = 1'b1;

      // First grant goes to req0; read miss returns the fresh-line value
      run(4, 0, 100);
      check("first_grant",  gq_id_at(0),  0);
      check("first_cyc",    gq_cyc_at(0), 0);
      check("miss_rsp_id",  obs_rsp_id,   0);
      check("miss_latency", obs_rsp_cyc - gq_cyc_at(0), 3);
      check("miss_rdata",   obs_rsp_data, 32'hDEADBEEF);

      // Write from req1 completes with rsp_rdata unchanged
      run(3, 0, 100);
      check("wr_grant",   gq_id_at(1),  1);
      check("wr_rsp_id",  obs_rsp_id,   1);
      check("wr_rdata",   obs_rsp_data, 32'hDEADBEEF);

      // Read hit of the written line
      hold[0] = 1'b1; r_rw[0] = 1'b0; r_addr[0] = 7'h08;
      run(4, 0, 100);
      check("hit_rsp_id", obs_rsp_id,   0);
      check("hit_rdata",  obs_rsp_data, 32'h12345678);

      // Cache stall: c_ready low for 4 ISSUE cycles
      hold[0] = 1'b1; r_rw[0] = 1'b1; r_addr[0] = 7'h10; r_din[0] = 32'hA5A5_0F0F;
      g = cyc;
      step(0, 100);
      for (int k = 0; k < 4; k++) begin
         check("stall_c_valid", c_valid, 1'b1);
         check("stall_c_addr",  c_addr,  7'h10);
         check("stall_c_din",   c_din,   32'hA5A5_0F0F);
         step(0, 0);
      end
      run(3, 0, 100);
      check("stall_latency", obs_rsp_cyc - g, 7);

      // Reset while in ISSUE
      hold[1] = 1'b1; r_rw[1] = 1'b0; r_addr[1] = 7'h03;
      step(0, 100);
      c_ready = 1'b0;
      check("abort_pre_valid", c_valid, 1'b1);
      rsp_before = rsp_cnt;
      #2 rst_n = 1'b0;
      #1 check("abort_c_valid", c_valid, 1'b0);
      check("abort_req_ready", req_ready, '0);
      @(negedge clk);
      @(negedge clk);
      model_reset();
      drive_ports();
      rst_n = 1'b1;
      run(6, 0, 100);
      check("abort_no_rsp", rsp_cnt, rsp_before);

      // Contention: both requesters continuously valid, cache always ready
      gq_id.delete();
      gq_cyc.delete();
      run(13, 100, 100);
      check("cont_count", gq_id.size() >= 4, 1'b1);
      for (int k = 0; k < 4; k++) begin
         check("cont_id",  gq_id_at(k), (RR_EN && (k % 2 == 1)) ? 1 : 0);
         check("cont_gap", gq_cyc_at(k) - gq_cyc_at(0), 3 * k);
      end

      // Long randomized run against the model
      run(3000, 40, 60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
